// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, two prioritised write ports,
// optional bypass, optional zero entry, pending scoreboard, clear engine.
//
// Ports:
//   clock, reset   : clock and synchronous active-high reset
//   init_busy      : high while the clear engine wipes the array
//   we0/wa0/wd0    : write port 0
//   we1/wa1/wd1    : write port 1, wins over port 0 on same address
//   ra / rd        : NRD packed read addresses / combinational read data
//   sb_set/sb_addr : mark one register pending (multi-cycle producer)
//   pending        : registered scoreboard bit per read port
module regfile_mp #(
   parameter int W        = 32,
   parameter int DEPTH    = 32,
   parameter int NRD      = 2,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              reset,
   output logic              init_busy,
   input  logic              we0,
   input  logic [AW-1:0]     wa0,
   input  logic [W-1:0]      wd0,
   input  logic              we1,
   input  logic [AW-1:0]     wa1,
   input  logic [W-1:0]      wd1,
   input  logic [NRD*AW-1:0] ra,
   output logic [NRD*W-1:0]  rd,
   input  logic              sb_set,
   input  logic [AW-1:0]     sb_addr,
   output logic [NRD-1:0]    pending
);

   localparam logic [0:0] S_CLEAR = 1'b0;
   localparam logic [0:0] S_READY = 1'b1;

   localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
   localparam bit ZR = (ZERO_REG != 0);
   localparam bit BP = (BYPASS != 0);

   logic [0:0]       state_q, state_d;
   logic [AW-1:0]    cnt_q, cnt_d;
   logic [DEPTH-1:0] sb_q, sb_d;
   logic [W-1:0]     mem_q [DEPTH];

   logic ready;
   logic wr0, wr1;

   assign ready     = (state_q == S_READY);
   assign init_busy = ~ready;

   // Writes that actually land; zero-entry writes are dropped.
   assign wr0 = ready && we0 && !(ZR && wa0 == '0);
   assign wr1 = ready && we1 && !(ZR && wa1 == '0);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      if (reset) begin
         state_d = S_CLEAR;
         cnt_d   = '0;
      end else if (!ready) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_q == LAST) begin
            state_d = S_READY;
         end
      end
   end

   // A new producer issued in the same cycle as a retiring write
   // keeps the register pending, so the set is applied last.
   always_comb begin
      sb_d = sb_q;
      if (ready) begin
         if (we0) begin
            sb_d[wa0] = 1'b0;
         end
         if (we1) begin
            sb_d[wa1] = 1'b0;
         end
         if (sb_set) begin
            sb_d[sb_addr] = 1'b1;
         end
      end
      if (reset) begin
         sb_d = '0;
      end
      if (ZR) begin
         sb_d[0] = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sb_q    <= sb_d;
   end

   // Array has no reset of its own; the clear engine zeroes it.
   // Port 1 is assigned last so it wins a same-address conflict.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (!ready) begin
            mem_q[cnt_q] <= '0;
         end else begin
            if (wr0) begin
               mem_q[wa0] <= wd0;
            end
            if (wr1) begin
               mem_q[wa1] <= wd1;
            end
         end
      end
   end

   for (genvar g = 0; g < NRD; g++) begin : g_rd
      logic [AW-1:0] a;
      logic [W-1:0]  v;

      assign a = ra[g*AW +: AW];

      always_comb begin
         v = mem_q[a];
         if (BP) begin
            if (wr0 && wa0 == a) begin
               v = wd0;
            end
            if (wr1 && wa1 == a) begin
               v = wd1;
            end
         end
         if (!ready || (ZR && a == '0)) begin
            v = '0;
         end
      end

      assign rd[g*W +: W] = v;
      assign pending[g]   = ready && sb_q[a];
   end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed plus random checks of regfile_mp against
// a behavioural model; one bypassing and one non-bypassing instance.
module tb_regfile_mp;

   localparam int W     = 32;
   localparam int DEPTH = 32;
   localparam int NRD   = 2;
   localparam int AW    = 5;

   logic              clock = 1'b0;
   logic              reset;
   logic              we0, we1, sb_set;
   logic [AW-1:0]     wa0, wa1, sb_addr;
   logic [W-1:0]      wd0, wd1;
   logic [NRD*AW-1:0] ra;

   logic              init_busy, init_busy_nb;
   logic [NRD*W-1:0]  rd, rd_nb;
   logic [NRD-1:0]    pending, pending_nb;

   int checks = 0;
   int errors = 0;

   // behavioural model
   bit          mvalid = 1'b0;
   int          m_left = DEPTH;
   logic [31:0] m_mem [DEPTH];
   bit          m_sb  [DEPTH];

   always #5 clock = ~clock;

   regfile_mp #(.W(W), .DEPTH(DEPTH), .NRD(NRD),
                .BYPASS(1), .ZERO_REG(1)) dut (
      .clock(clock), .reset(reset), .init_busy(init_busy),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd),
      .sb_set(sb_set), .sb_addr(sb_addr), .pending(pending)
   );

   regfile_mp #(.W(W), .DEPTH(DEPTH), .NRD(NRD),
                .BYPASS(0), .ZERO_REG(1)) dut_nb (
      .clock(clock), .reset(reset), .init_busy(init_busy_nb),
      .we0(we0), .wa0(wa0), .wd0(wd0),
      .we1(we1), .wa1(wa1), .wd1(wd1),
      .ra(ra), .rd(rd_nb),
      .sb_set(sb_set), .sb_addr(sb_addr), .pending(pending_nb)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check_all();
      logic [AW-1:0] a;
      logic [31:0]   e, enb;
      bit            busy;
      if (!mvalid) return;
      busy = (m_left > 0);
      chk("busy", {31'b0, init_busy}, {31'b0, busy});
      chk("busy_nb", {31'b0, init_busy_nb}, {31'b0, busy});
      for (int k = 0; k < NRD; k++) begin
         a = ra[k*AW +: AW];
         enb = (busy || a == 0) ? 32'h0 : m_mem[a];
         e = enb;
         if (!busy && a != 0) begin
            if (we0 && wa0 == a) e = wd0;
            if (we1 && wa1 == a) e = wd1;
         end
         chk($sformatf("rd%0d_a%0d", k, a), rd[k*W +: W], e);
         chk($sformatf("rdnb%0d_a%0d", k, a), rd_nb[k*W +: W], enb);
         chk($sformatf("pend%0d_a%0d", k, a), {31'b0, pending[k]},
             {31'b0, (!busy && m_sb[a])});
         chk($sformatf("pendnb%0d_a%0d", k, a), {31'b0, pending_nb[k]},
             {31'b0, (!busy && m_sb[a])});
      end
   endtask

   task automatic model_update();
      if (reset) begin
         mvalid = 1'b1;
         m_left = DEPTH;
         for (int i = 0; i < DEPTH; i++) begin
            m_mem[i] = 32'h0;
            m_sb[i]  = 1'b0;
         end
      end else if (m_left > 0) begin
         m_left--;
      end else begin
         if (we0 && wa0 != 0) m_mem[wa0] = wd0;
         if (we1 && wa1 != 0) m_mem[wa1] = wd1;
         if (we0) m_sb[wa0] = 1'b0;
         if (we1) m_sb[wa1] = 1'b0;
         if (sb_set && sb_addr != 0) m_sb[sb_addr] = 1'b1;
      end
   endtask

   task automatic cyc();
      @(negedge clock);
      check_all();
      @(posedge clock);
      model_update();
      #1;
   endtask

   initial begin
      int n;
      reset = 1'b1;
      we0 = 0; wa0 = 0; wd0 = 0;
      we1 = 0; wa1 = 0; wd1 = 0;
      sb_set = 0; sb_addr = 0; ra = '0;
      cyc();
      reset = 1'b0;

      // clear sequence: writes and sb_set must be ignored
      we0 = 1; wa0 = 5; wd0 = 32'h1234; sb_set = 1; sb_addr = 9;
      ra = {5'd9, 5'd5};
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (i == 20) begin
            we0 = 0;
            sb_set = 0;
         end
         if (init_busy === 1'b1) n++;
         cyc();
      end
      chk("busy_len", n, 32);
      chk("busy_low", {31'b0, init_busy}, 32'h0);
      chk("clr_drop5", rd[31:0], 32'h0);
      chk("clr_sb9", {31'b0, pending[1]}, 32'h0);

      // bypass vs no bypass
      we0 = 1; wa0 = 3; wd0 = 32'hDEADBEEF; ra = {5'd0, 5'd3};
      #1;
      chk("byp", rd[31:0], 32'hDEADBEEF);
      chk("nobyp_old", rd_nb[31:0], 32'h0);
      cyc();
      we0 = 0;
      #1;
      chk("nobyp_new", rd_nb[31:0], 32'hDEADBEEF);

      // same-address conflict
      we0 = 1; wa0 = 7; wd0 = 32'h11;
      we1 = 1; wa1 = 7; wd1 = 32'h22;
      ra = {5'd7, 5'd7};
      #1;
      chk("conf_byp", rd[63:32], 32'h22);
      cyc();
      we0 = 0; we1 = 0;
      #1;
      chk("conf_store", rd_nb[31:0], 32'h22);

      // zero register
      we0 = 1; wa0 = 0; wd0 = 32'h55; sb_set = 1; sb_addr = 0;
      ra = {5'd0, 5'd0};
      #1;
      chk("zero_byp", rd[31:0], 32'h0);
      cyc();
      we0 = 0; sb_set = 0;
      #1;
      chk("zero_rd", rd_nb[31:0], 32'h0);
      chk("zero_pend", {30'b0, pending}, 32'h0);

      // scoreboard
      sb_set = 1; sb_addr = 9; ra = {5'd9, 5'd9};
      cyc();
      sb_set = 0;
      #1;
      chk("sb_set", {31'b0, pending[0]}, 32'h1);
      we1 = 1; wa1 = 9; wd1 = 32'h99;
      cyc();
      we1 = 0;
      #1;
      chk("sb_clr", {31'b0, pending[0]}, 32'h0);
      we0 = 1; wa0 = 9; wd0 = 32'hA5; sb_set = 1; sb_addr = 9;
      cyc();
      we0 = 0; sb_set = 0;
      #1;
      chk("sb_both", {31'b0, pending[0]}, 32'h1);

      // reset in the middle of the clear
      sb_set = 1; sb_addr = 12;
      cyc();
      sb_set = 0; ra = {5'd12, 5'd9};
      reset = 1;
      cyc();
      reset = 0;
      repeat (10) cyc();
      reset = 1;
      cyc();
      reset = 0;
      n = 0;
      for (int i = 0; i < 40; i++) begin
         if (init_busy === 1'b1) n++;
         cyc();
      end
      chk("mid_busy_len", n, 32);
      chk("mid_pend", {30'b0, pending}, 32'h0);
      chk("mid_rd9", rd[31:0], 32'h0);

      // random traffic against the model
      for (int i = 0; i < 500; i++) begin
         we0 = 1'($urandom_range(0, 1));
         we1 = 1'($urandom_range(0, 1));
         sb_set = ($urandom_range(0, 3) == 0);
         wa0 = 5'($urandom_range(0, 7));
         wa1 = 5'($urandom_range(0, 7));
         sb_addr = 5'($urandom_range(0, 7));
         wd0 = $urandom;
         wd1 = $urandom;
         ra = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 31))};
         reset = ($urandom_range(0, 199) == 0);
         cyc();
      end
      reset = 0;
      we0 = 0; we1 = 0; sb_set = 0;
      cyc();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
